// File: rtl/serial_tx_fsm.sv
// serial_tx_fsm: parallel-to-serial line transmitter.
// Frame: start bit (0), DATA_W data bits, optional odd-parity bit, STOP_BITS stop bits (1).
// Each bit is held for BIT_CYCLES clocks. The line idles high.
// Optional feature macro: SERIAL_TX_PARITY_EN inserts one odd-parity bit before the stop bits.
// Ports:
//   clk      - clock, rising edge
//   reset    - synchronous reset, active-high
//   in_byte  - byte to send, latched on acceptance
//   in_valid - upstream has a byte
//   in_ready - combinational; byte can be accepted this cycle
//   out      - registered serial line
//   busy     - registered; high while a frame bit is on the line
module serial_tx_fsm #(
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned MSB_FIRST  = 1,
    parameter int unsigned BIT_CYCLES = 1,
    parameter int unsigned STOP_BITS  = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] in_byte,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              out,
    output logic              busy
);

    localparam int unsigned CYC_W = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
    localparam int unsigned BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CYC_W-1:0] CYC_LAST  = CYC_W'(BIT_CYCLES - 1);
    localparam logic [BIT_W-1:0] DATA_LAST = BIT_W'(DATA_W - 1);
    localparam logic [BIT_W-1:0] STOP_LAST = BIT_W'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_STOP   = 3'd3
`ifdef SERIAL_TX_PARITY_EN
        , S_PARITY = 3'd4
`endif
    } state_t;

    state_t              r_state, w_state_nxt;
    logic [CYC_W-1:0]    r_cyc, w_cyc_nxt;
    logic [BIT_W-1:0]    r_bit, w_bit_nxt;
    logic [DATA_W-1:0]   r_shift, w_shift_nxt;
    logic [DATA_W-1:0]   w_shifted;
    logic                r_out, w_out_nxt;
    logic                r_busy, w_busy_nxt;
    logic                w_bit_last;
    logic                w_ready;
    logic                w_accept;
`ifdef SERIAL_TX_PARITY_EN
    logic                r_parity, w_parity_nxt;
`endif

    // Last clock of the bit currently on the line
    assign w_bit_last = (r_cyc == CYC_LAST);

    // Ready in IDLE, or in the final clock of the final stop bit for back-to-back frames
    assign w_ready  = ~reset & ((r_state == S_IDLE) |
                                ((r_state == S_STOP) & (r_bit == STOP_LAST) & w_bit_last));
    assign w_accept = in_valid & w_ready;
    assign in_ready = w_ready;

    // Move the next data bit to the output end of the shift register
    assign w_shifted = (MSB_FIRST != 0) ? {r_shift[DATA_W-2:0], 1'b0}
                                        : {1'b0, r_shift[DATA_W-1:1]};

    // Next-state, counters and the registered line value for the next clock
    always_comb begin
        w_state_nxt  = r_state;
        w_cyc_nxt    = r_cyc;
        w_bit_nxt    = r_bit;
        w_shift_nxt  = r_shift;
        w_out_nxt    = 1'b1;
        w_busy_nxt   = 1'b0;
`ifdef SERIAL_TX_PARITY_EN
        w_parity_nxt = r_parity;
`endif
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_state_nxt  = S_START;
                    w_cyc_nxt    = '0;
                    w_bit_nxt    = '0;
                    w_shift_nxt  = in_byte;
`ifdef SERIAL_TX_PARITY_EN
                    w_parity_nxt = ~^in_byte;
`endif
                end
            end
            S_START: begin
                if (w_bit_last) begin
                    w_state_nxt = S_DATA;
                    w_cyc_nxt   = '0;
                    w_bit_nxt   = '0;
                end else begin
                    w_cyc_nxt = r_cyc + CYC_W'(1);
                end
            end
            S_DATA: begin
                if (w_bit_last) begin
                    w_cyc_nxt = '0;
                    if (r_bit == DATA_LAST) begin
                        w_bit_nxt = '0;
`ifdef SERIAL_TX_PARITY_EN
                        w_state_nxt = S_PARITY;
`else
                        w_state_nxt = S_STOP;
`endif
                    end else begin
                        w_bit_nxt   = r_bit + BIT_W'(1);
                        w_shift_nxt = w_shifted;
                    end
                end else begin
                    w_cyc_nxt = r_cyc + CYC_W'(1);
                end
            end
`ifdef SERIAL_TX_PARITY_EN
            S_PARITY: begin
                if (w_bit_last) begin
                    w_state_nxt = S_STOP;
                    w_cyc_nxt   = '0;
                    w_bit_nxt   = '0;
                end else begin
                    w_cyc_nxt = r_cyc + CYC_W'(1);
                end
            end
`endif
            S_STOP: begin
                if (w_bit_last) begin
                    w_cyc_nxt = '0;
                    if (r_bit == STOP_LAST) begin
                        w_bit_nxt = '0;
                        if (w_accept) begin
                            w_state_nxt  = S_START;
                            w_shift_nxt  = in_byte;
`ifdef SERIAL_TX_PARITY_EN
                            w_parity_nxt = ~^in_byte;
`endif
                        end else begin
                            w_state_nxt = S_IDLE;
                        end
                    end else begin
                        w_bit_nxt = r_bit + BIT_W'(1);
                    end
                end else begin
                    w_cyc_nxt = r_cyc + CYC_W'(1);
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_cyc_nxt   = '0;
                w_bit_nxt   = '0;
            end
        endcase

        // Line value follows the state being entered so out is registered with no lag
        case (w_state_nxt)
            S_START: w_out_nxt = 1'b0;
            S_DATA:  w_out_nxt = (MSB_FIRST != 0) ? w_shift_nxt[DATA_W-1] : w_shift_nxt[0];
`ifdef SERIAL_TX_PARITY_EN
            S_PARITY: w_out_nxt = w_parity_nxt;
`endif
            default: w_out_nxt = 1'b1;
        endcase
        w_busy_nxt = (w_state_nxt != S_IDLE);
    end

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_cyc    <= '0;
            r_bit    <= '0;
            r_shift  <= '0;
            r_out    <= 1'b1;
            r_busy   <= 1'b0;
`ifdef SERIAL_TX_PARITY_EN
            r_parity <= 1'b0;
`endif
        end else begin
            r_state  <= w_state_nxt;
            r_cyc    <= w_cyc_nxt;
            r_bit    <= w_bit_nxt;
            r_shift  <= w_shift_nxt;
            r_out    <= w_out_nxt;
            r_busy   <= w_busy_nxt;
`ifdef SERIAL_TX_PARITY_EN
            r_parity <= w_parity_nxt;
`endif
        end
    end

    assign out  = r_out;
    assign busy = r_busy;

endmodule
